// File: rtl/gpio_in_cond_pkg.sv
// Shared definitions for the switch-input conditioner: register map and
// the decoded form of a CPU register access.
package gpio_in_cond_pkg;

  // CPU data bus width of the register window.
  localparam int unsigned REG_W = 8;

  // Register addresses, kept in step with the firmware header.
  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_STATUS  = 2'd1,
    ADDR_RISE_EN = 2'd2,
    ADDR_FALL_EN = 2'd3
  } reg_addr_e;

  // One decoded CPU access for the current cycle.
  typedef struct packed {
    logic      rd;
    logic      wr;
    reg_addr_e addr;
  } cpu_req_t;

  // Qualify the raw strobe/direction pair into read and write pulses.
  function automatic cpu_req_t decode_req(input logic sel, input logic we,
                                          input logic [1:0] addr);
    cpu_req_t req;
    req.rd   = sel & ~we;
    req.wr   = sel & we;
    req.addr = reg_addr_e'(addr);
    return req;
  endfunction

endpackage

// File: rtl/gpio_in_cond_in_debounce.sv
// One switch bit: two-flop synchronizer, hold-time debounce counter,
// debounced level and single-cycle rise/fall events on acceptance.
module in_debounce
  import gpio_in_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE  = 12000,
  parameter int unsigned CNT_W     = 14,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // The synchronizer flops reset to the idle level so that leaving reset
  // never looks like a pending change to the counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
    end else begin
      s1 <= pin;
      s2 <= s1;
    end
  end

  // A new level is taken only after DEBOUNCE consecutive differing samples.
  assign accept = (s2 != level) && (cnt == CNT_LAST);

  // Counter restarts whenever the synchronized input agrees with the level,
  // so a glitch back to the old level discards all accumulated credit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      level <= RESET_VAL;
    end else if (s2 == level) begin
      cnt <= '0;
    end else if (accept) begin
      cnt   <= '0;
      level <= s2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // accept already implies s2 differs from level, so s2 gives the direction.
  assign rise = accept & s2;
  assign fall = accept & ~s2;

endmodule

// File: rtl/gpio_in_cond.sv
// Conditions the board switches for the MCU: per-bit synchronize and
// debounce, latch enabled edges into a write-1-to-clear STATUS register,
// and raise a level interrupt while any STATUS bit is set.
//
// CPU access: sel is a one-cycle strobe. With we=1 the write takes effect
// on that clock edge; with we=0 dout is loaded with the addressed register
// on that edge and then holds until the next read strobe.
module gpio_in_cond
  import gpio_in_cond_pkg::*;
#(
  parameter int unsigned      WIDTH       = 4,
  parameter int unsigned      DEBOUNCE    = 12000,
  parameter int unsigned      CNT_W       = 14,
  parameter logic [WIDTH-1:0] RESET_LEVEL = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] level_o,
  input  logic             sel,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [REG_W-1:0] din,
  output logic [REG_W-1:0] dout,
  output logic             irq_o
);

  cpu_req_t         req;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] status;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] w1c_mask;
  logic [REG_W-1:0] rd_data;
  logic             unused_din;

  // Write data bits above WIDTH have no storage behind them.
  assign unused_din = ^din;

  assign req = decode_req(sel, we, addr);

  // One conditioner per switch bit.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    in_debounce #(
      .DEBOUNCE (DEBOUNCE),
      .CNT_W    (CNT_W),
      .RESET_VAL(RESET_LEVEL[i])
    ) u_in_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .pin    (pin_i[i]),
      .level  (level_o[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  // Edge qualification uses the enables as they stood before this cycle's
  // write; the W1C mask only covers a STATUS write.
  always_comb begin
    edge_set = (rise & rise_en) | (fall & fall_en);
    w1c_mask = '0;
    if (req.wr && (req.addr == ADDR_STATUS)) begin
      w1c_mask = din[WIDTH-1:0];
    end
  end

  // Read mux; bits above WIDTH read as zero.
  always_comb begin
    rd_data = '0;
    unique case (req.addr)
      ADDR_DATA:    rd_data[WIDTH-1:0] = level_o;
      ADDR_STATUS:  rd_data[WIDTH-1:0] = status;
      ADDR_RISE_EN: rd_data[WIDTH-1:0] = rise_en;
      ADDR_FALL_EN: rd_data[WIDTH-1:0] = fall_en;
      default:      rd_data = '0;
    endcase
  end

  // STATUS: clear then set, so an edge in the same cycle as its W1C wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status <= '0;
    end else begin
      status <= (status & ~w1c_mask) | edge_set;
    end
  end

  // Edge enable masks, plain read/write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_en <= '0;
      fall_en <= '0;
    end else if (req.wr) begin
      if (req.addr == ADDR_RISE_EN) rise_en <= din[WIDTH-1:0];
      if (req.addr == ADDR_FALL_EN) fall_en <= din[WIDTH-1:0];
    end
  end

  // Registered read data, updated only on a read strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout <= '0;
    end else if (req.rd) begin
      dout <= rd_data;
    end
  end

  // Interrupt follows STATUS one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= |status;
    end
  end

endmodule

// File: tb/tb_gpio_in_cond.sv
// Bench for gpio_in_cond with DEBOUNCE=8, WIDTH=4. A reference model
// evaluated at every rising edge predicts level_o, irq_o and dout; the
// debounce rule is modelled as a sliding window of synchronized samples.
module tb_gpio_in_cond;

  localparam int D = 8;
  localparam int W = 4;

  logic       clk;
  logic       reset_n;
  logic [3:0] pin_i;
  logic [3:0] level_o;
  logic       sel;
  logic       we;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq_o;

  int n_cmp;
  int n_fail;

  // Reference model state
  logic [3:0] m_level;
  logic [3:0] m_status;
  logic [3:0] m_ren;
  logic [3:0] m_fen;
  logic       m_irq;
  logic [7:0] m_dout;
  logic [3:0] pin_hist[$];
  logic [3:0] win_q[$];

  gpio_in_cond #(
    .WIDTH      (W),
    .DEBOUNCE   (D),
    .CNT_W      (4),
    .RESET_LEVEL(4'hF)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .pin_i  (pin_i),
    .level_o(level_o),
    .sel    (sel),
    .we     (we),
    .addr   (addr),
    .din    (din),
    .dout   (dout),
    .irq_o  (irq_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_level  = 4'hF;
    m_status = 4'h0;
    m_ren    = 4'h0;
    m_fen    = 4'h0;
    m_irq    = 1'b0;
    m_dout   = 8'h00;
    pin_hist = {4'hF, 4'hF};
    win_q.delete();
    repeat (D) win_q.push_back(4'hF);
  endtask

  // A bit changes level once its last D synchronized samples all differ
  // from the current level; the synchronized sample lags the pin by two edges.
  task automatic model_edge();
    logic [3:0] s2pre, lvl_n, rise, fall, clr;
    logic [7:0] rdv;
    bit flip;
    s2pre = pin_hist[0];
    void'(pin_hist.pop_front());
    pin_hist.push_back(pin_i);
    win_q.push_back(s2pre);
    void'(win_q.pop_front());
    for (int i = 0; i < W; i++) begin
      flip = 1'b1;
      foreach (win_q[k]) if (win_q[k][i] == m_level[i]) flip = 1'b0;
      lvl_n[i] = flip ? ~m_level[i] : m_level[i];
    end
    rise = lvl_n & ~m_level;
    fall = ~lvl_n & m_level;
    case (addr)
      2'd0:    rdv = {4'h0, m_level};
      2'd1:    rdv = {4'h0, m_status};
      2'd2:    rdv = {4'h0, m_ren};
      default: rdv = {4'h0, m_fen};
    endcase
    clr = (sel && we && addr == 2'd1) ? din[3:0] : 4'h0;
    m_irq = |m_status;
    if (sel && !we) m_dout = rdv;
    m_status = (m_status & ~clr) | (rise & m_ren) | (fall & m_fen);
    if (sel && we && addr == 2'd2) m_ren = din[3:0];
    if (sel && we && addr == 2'd3) m_fen = din[3:0];
    m_level = lvl_n;
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge.
  task automatic step();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_edge();
    @(negedge clk);
    check("level_model", {4'h0, level_o}, {4'h0, m_level});
    check("irq_model", {7'h0, irq_o}, {7'h0, m_irq});
    check("dout_model", dout, m_dout);
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    sel = 1'b1; we = 1'b1; addr = a; din = d;
    step();
    sel = 1'b0; we = 1'b0; din = 8'h00;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
    sel = 1'b1; we = 1'b0; addr = a;
    step();
    sel = 1'b0;
    check(tag, dout, exp);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    pin_i = 4'hF; sel = 1'b0; we = 1'b0; addr = 2'd0; din = 8'h00;
    reset_n = 1'b0;
    model_reset();
    settle(3);
    reset_n = 1'b1;
    step();

    // 1. Reset state
    check("rst_level", {4'h0, level_o}, 8'h0F);
    check("rst_irq", {7'h0, irq_o}, 8'h00);
    check("rst_dout", dout, 8'h00);
    rd("rst_data", 2'd0, 8'h0F);
    rd("rst_status", 2'd1, 8'h00);
    rd("rst_rise_en", 2'd2, 8'h00);
    rd("rst_fall_en", 2'd3, 8'h00);

    // 2. Clean falling step on bit 0: exactly 10 cycles to level_o
    pin_i[0] = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      check("lat_early", {7'h0, level_o[0]}, 8'h01);
    end
    step();
    check("lat_exact", {7'h0, level_o[0]}, 8'h00);
    pin_i[0] = 1'b1;
    settle(12);
    check("lat_restore", {4'h0, level_o}, 8'h0F);

    // 3. Short low pulses on bit 1 never accepted
    wr(2'd3, 8'h0F);
    for (int r = 0; r < 3; r++) begin
      pin_i[1] = 1'b0;
      repeat (5) begin
        step();
        check("glitch_level", {4'h0, level_o}, 8'h0F);
      end
      pin_i[1] = 1'b1;
      repeat (2) begin
        step();
        check("glitch_level", {4'h0, level_o}, 8'h0F);
      end
    end
    settle(10);
    rd("glitch_status", 2'd1, 8'h00);

    // 4. Falling edge flagged, IRQ one cycle later, W1C clears
    wr(2'd3, 8'h01);
    pin_i[0] = 1'b0;
    settle(10);
    check("fall_irq_same", {7'h0, irq_o}, 8'h00);
    step();
    check("fall_irq_next", {7'h0, irq_o}, 8'h01);
    rd("fall_status", 2'd1, 8'h01);
    wr(2'd1, 8'h01);
    step();
    check("w1c_irq", {7'h0, irq_o}, 8'h00);
    rd("w1c_status", 2'd1, 8'h00);
    pin_i[0] = 1'b1;
    settle(12);

    // 5. W1C of bit 2 on the cycle rise[2] fires: set wins
    wr(2'd2, 8'h04);
    pin_i[2] = 1'b0;
    settle(12);
    pin_i[2] = 1'b1;
    settle(9);
    sel = 1'b1; we = 1'b1; addr = 2'd1; din = 8'h04;
    step();
    sel = 1'b0; we = 1'b0; din = 8'h00;
    check("race_level", {7'h0, level_o[2]}, 8'h01);
    step();
    check("race_irq", {7'h0, irq_o}, 8'h01);
    rd("race_status", 2'd1, 8'h04);
    wr(2'd1, 8'h04);
    settle(2);
    check("race_clr_irq", {7'h0, irq_o}, 8'h00);

    // 6. Reset in the middle of a pending change
    wr(2'd3, 8'h08);
    pin_i[3] = 1'b0;
    settle(7);
    reset_n = 1'b0;
    #1;
    check("mid_rst_level", {4'h0, level_o}, 8'h0F);
    check("mid_rst_irq", {7'h0, irq_o}, 8'h00);
    check("mid_rst_dout", dout, 8'h00);
    settle(2);
    reset_n = 1'b1;
    settle(12);
    rd("mid_rst_status", 2'd1, 8'h00);
    rd("mid_rst_fall_en", 2'd3, 8'h00);
    pin_i[3] = 1'b1;
    settle(12);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 11) == 0) pin_i[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        sel  = 1'b1;
        we   = 1'($urandom_range(0, 1));
        addr = 2'($urandom_range(0, 3));
        din  = 8'($urandom_range(0, 255));
      end else begin
        sel = 1'b0; we = 1'b0;
      end
      step();
    end
    sel = 1'b0; we = 1'b0;
    settle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
